// File: rtl/ddr_pkg.sv
// ddr_pkg: shared widths, responder state encoding and latched-command layout
package ddr_pkg;
    localparam int DDR_INDEX_WIDTH = 19;
    localparam int DDR_WORD_WIDTH  = 64;
    localparam int DDR_BURST_BEATS = 8;
    localparam int DDR_LINE_WIDTH  = 512;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} ddr_state_t;

    typedef struct packed {
        logic [DDR_INDEX_WIDTH-1:0] index;
        logic                       we;
        logic                       burst;
        logic [DDR_WORD_WIDTH-1:0]  mask;
        logic [DDR_WORD_WIDTH-1:0]  data;
    } ddr_cmd_t;
endpackage

// File: rtl/ddr_mem_array.sv
// ddr_mem_array: single-port word array, combinational read, per-bit masked synchronous write
module ddr_mem_array import ddr_pkg::*; #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                      clock,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic                      we,
    input  logic [DDR_WORD_WIDTH-1:0] mask,
    input  logic [DDR_WORD_WIDTH-1:0] data,
    output logic [DDR_WORD_WIDTH-1:0] rd_data
);
    logic [DDR_WORD_WIDTH-1:0] mem [2**ADDR_WIDTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clock) begin
        if (we) mem[addr] <= (mem[addr] & ~mask) | (data & mask);
    end
endmodule

// File: rtl/ddr_responder.sv
// ddr_responder: memory-side endpoint of the DDR command channel with fixed latencies,
// masked writes, single reads and 8-beat burst reads; one command outstanding at a time
module ddr_responder import ddr_pkg::*; #(
    parameter int MEM_ADDR_WIDTH = 12,
    parameter int READ_LATENCY   = 4,
    parameter int WRITE_LATENCY  = 3,
    parameter int BURST_BEATS    = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       ddr_chip_enable,
    input  logic [DDR_INDEX_WIDTH-1:0] ddr_index,
    input  logic                       ddr_write_enable,
    input  logic                       ddr_burst_mode,
    input  logic [DDR_WORD_WIDTH-1:0]  ddr_opstore_write_mask,
    input  logic [DDR_WORD_WIDTH-1:0]  ddr_opstore_write_data,
    output logic [DDR_WORD_WIDTH-1:0]  ddr_opload_read_data,
    output logic [DDR_LINE_WIDTH-1:0]  ddr_pc_read_inst,
    output logic                       ddr_operation_done,
    output logic                       ddr_ready
);
    localparam int MAX_LAT = READ_LATENCY > WRITE_LATENCY ? READ_LATENCY : WRITE_LATENCY;
    localparam int CW = $clog2(MAX_LAT + 1);

    ddr_state_t state, state_nx;
    ddr_cmd_t cmd, cur, incoming;
    logic [CW-1:0] cnt, lat_in;
    logic [2:0] beat;
    logic [DDR_LINE_WIDTH-DDR_WORD_WIDTH-1:0] line_q;
    logic accept, capture, rd_single, mem_we, unused_hi;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [DDR_WORD_WIDTH-1:0] rd_data;

    assign incoming = '{index: ddr_index, we: ddr_write_enable, burst: ddr_burst_mode,
                        mask: ddr_opstore_write_mask, data: ddr_opstore_write_data};
    assign lat_in = (ddr_write_enable && !ddr_burst_mode) ? CW'(WRITE_LATENCY) : CW'(READ_LATENCY);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    end

    // A latency of 1 skips WAIT; bursts then capture beat 0 straight from the incoming index
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = lat_in == CW'(1) ? (ddr_burst_mode ? BURST : DONE) : WAIT;
            WAIT:    if (cnt == CW'(1)) state_nx = cmd.burst ? BURST : DONE;
            BURST:   if (beat == 3'(BURST_BEATS - 1)) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        accept = ddr_chip_enable && state == IDLE;
        cur = state == IDLE ? incoming : cmd;
        addr = cur.burst ? {cur.index[MEM_ADDR_WIDTH-1:3], beat} : cur.index[MEM_ADDR_WIDTH-1:0];
        mem_we = state == DONE && cmd.we && !cmd.burst;
        capture = state_nx == BURST;
        rd_single = state_nx == DONE && state != BURST && !cur.we && !cur.burst;
        ddr_ready = state == IDLE;
        ddr_operation_done = state == DONE;
        unused_hi = ^cur.index;
    end

    // The last beat bypasses line_q so the whole line lands on the edge into DONE
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd <= '0;
            cnt <= '0;
            beat <= '0;
            line_q <= '0;
            ddr_opload_read_data <= '0;
            ddr_pc_read_inst <= '0;
        end else begin
            if (accept) begin
                cmd <= incoming;
                cnt <= lat_in - CW'(1);
            end else if (state == WAIT) cnt <= cnt - CW'(1);
            if (capture) begin
                line_q[DDR_WORD_WIDTH*beat +: DDR_WORD_WIDTH] <= rd_data;
                beat <= beat + 3'd1;
            end
            if (state == BURST && state_nx == DONE) begin
                ddr_pc_read_inst <= {rd_data, line_q};
                beat <= '0;
            end
            if (rd_single) ddr_opload_read_data <= rd_data;
        end
    end

    ddr_mem_array #(.ADDR_WIDTH(MEM_ADDR_WIDTH)) u_mem (
        .clock  (clock),
        .addr   (addr),
        .we     (mem_we),
        .mask   (cur.mask),
        .data   (cur.data),
        .rd_data(rd_data)
    );

    busy_strobe_ignored: assert property (@(posedge clock) disable iff (!reset_n)
        !(ddr_chip_enable && !ddr_ready))
        else $warning("ddr_responder: ddr_chip_enable while busy is ignored");
endmodule

// File: tb/tb_ddr_responder.sv
// tb_ddr_responder: scenario tasks with a scoreboard of expected read words and burst lines
module tb_ddr_responder;
    import ddr_pkg::*;
    localparam int RL = 4;
    localparam int WL = 3;

    logic clock = 0, reset_n = 0;
    logic ddr_chip_enable = 0, ddr_write_enable = 0, ddr_burst_mode = 0;
    logic [18:0] ddr_index = '0;
    logic [63:0] ddr_opstore_write_mask = '0, ddr_opstore_write_data = '0;
    logic [63:0] ddr_opload_read_data;
    logic [511:0] ddr_pc_read_inst;
    logic ddr_operation_done, ddr_ready;

    int n_cmp = 0, n_err = 0;
    logic [63:0] model [int];
    logic [63:0] word_q [$];
    logic [511:0] line_q [$];
    logic [63:0] last_rd = '0;
    logic [511:0] last_pc = '0;

    ddr_responder #(.MEM_ADDR_WIDTH(12), .READ_LATENCY(RL), .WRITE_LATENCY(WL), .BURST_BEATS(8)) dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .ddr_chip_enable       (ddr_chip_enable),
        .ddr_index             (ddr_index),
        .ddr_write_enable      (ddr_write_enable),
        .ddr_burst_mode        (ddr_burst_mode),
        .ddr_opstore_write_mask(ddr_opstore_write_mask),
        .ddr_opstore_write_data(ddr_opstore_write_data),
        .ddr_opload_read_data  (ddr_opload_read_data),
        .ddr_pc_read_inst      (ddr_pc_read_inst),
        .ddr_operation_done    (ddr_operation_done),
        .ddr_ready             (ddr_ready)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] mrd(input logic [18:0] idx);
        int a = int'(idx[11:0]);
        return model.exists(a) ? model[a] : 'x;
    endfunction

    function automatic logic [511:0] mline(input logic [18:0] idx);
        logic [511:0] l;
        for (int k = 0; k < 8; k++) l[64*k +: 64] = mrd({idx[18:3], 3'(k)});
        return l;
    endfunction

    // Starts and ends at a negedge with ddr_ready expected high
    task automatic do_cmd(input logic we, input logic burst, input logic [18:0] idx,
                          input logic [63:0] mask, input logic [63:0] data, input string name);
        int lat, exp_lat;
        logic [63:0] ew;
        logic [511:0] el;
        exp_lat = burst ? RL + 7 : (we ? WL : RL);
        if (burst) line_q.push_back(mline(idx));
        else if (!we) word_q.push_back(mrd(idx));
        ddr_chip_enable = 1; ddr_write_enable = we; ddr_burst_mode = burst;
        ddr_index = idx; ddr_opstore_write_mask = mask; ddr_opstore_write_data = data;
        @(posedge clock);
        @(negedge clock);
        ddr_chip_enable = 0;
        n_cmp++;
        if (ddr_ready !== 1'b0) begin n_err++; $display("FAIL %s_busy: ready=%b expected 0", name, ddr_ready); end
        lat = 1;
        while (ddr_operation_done !== 1'b1 && lat < 40) begin @(negedge clock); lat++; end
        n_cmp++;
        if (lat !== exp_lat) begin n_err++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat); end
        if (burst) begin
            el = line_q.pop_front();
            n_cmp += 2;
            if (ddr_pc_read_inst !== el) begin n_err++; $display("FAIL %s_line: got %h expected %h", name, ddr_pc_read_inst, el); end
            if (ddr_opload_read_data !== last_rd) begin n_err++; $display("FAIL %s_opload_kept: got %h expected %h", name, ddr_opload_read_data, last_rd); end
            last_pc = el;
        end else if (!we) begin
            ew = word_q.pop_front();
            n_cmp += 2;
            if (ddr_opload_read_data !== ew) begin n_err++; $display("FAIL %s_data: got %h expected %h", name, ddr_opload_read_data, ew); end
            if (ddr_pc_read_inst !== last_pc) begin n_err++; $display("FAIL %s_line_kept: got %h expected %h", name, ddr_pc_read_inst, last_pc); end
            last_rd = ew;
        end else model[int'(idx[11:0])] = (mrd(idx) & ~mask) | (data & mask);
        @(negedge clock);
        n_cmp++;
        if ({ddr_ready, ddr_operation_done} !== 2'b10) begin
            n_err++; $display("FAIL %s_ready_after: ready,done=%b expected 10", name, {ddr_ready, ddr_operation_done});
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({ddr_ready, ddr_operation_done, ddr_opload_read_data, ddr_pc_read_inst} !== {2'b10, 576'b0}) begin
            n_err++; $display("FAIL reset_state: ready=%b done=%b opload=%h pc=%h expected 1 0 0 0",
                              ddr_ready, ddr_operation_done, ddr_opload_read_data, ddr_pc_read_inst);
        end
        reset_n = 1;
        @(negedge clock);
        n_cmp++;
        if (ddr_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b expected 1", ddr_ready); end
    endtask

    task automatic test_write_read();
        do_cmd(1, 0, 19'h00010, '1, 64'hDEADBEEF_CAFEF00D, "wr_full");
        do_cmd(0, 0, 19'h00010, '0, '0, "rd_full");
    endtask

    task automatic test_masked_write();
        do_cmd(1, 0, 19'h00010, 64'h00000000_FFFFFFFF, 64'h0, "wr_mask");
        do_cmd(0, 0, 19'h00010, '0, '0, "rd_mask");
        do_cmd(1, 0, 19'h00010, 64'h0, 64'h1234, "wr_mask0");
        do_cmd(0, 0, 19'h00010, '0, '0, "rd_mask0");
    endtask

    task automatic test_burst();
        for (int k = 0; k < 8; k++) do_cmd(1, 0, 19'h20 + 19'(k), '1, 64'h100 + 64'(k), "wr_line");
        do_cmd(0, 1, 19'h00023, '0, '0, "burst_23");
        do_cmd(0, 0, 19'h00024, '0, '0, "rd_after_burst");
    endtask

    task automatic test_ce_spam();
        int dones = 0, done_at = -10;
        logic [63:0] ew;
        do_cmd(1, 0, 19'h00040, '1, 64'h1111, "wr_spam_seed");
        word_q.push_back(mrd(19'h40));
        ddr_chip_enable = 1; ddr_write_enable = 0; ddr_burst_mode = 0; ddr_index = 19'h40;
        @(posedge clock);
        @(negedge clock);
        ddr_write_enable = 1; ddr_opstore_write_mask = '1; ddr_opstore_write_data = 64'hBAD0_BAD0_BAD0_BAD0;
        for (int c = 1; c <= 15; c++) begin
            if (c == done_at + 1) begin
                n_cmp++;
                if (ddr_ready !== 1'b1) begin n_err++; $display("FAIL spam_ready_after: got %b expected 1", ddr_ready); end
            end
            if (ddr_operation_done === 1'b1) begin
                dones++;
                done_at = c;
                ddr_chip_enable = 0;
                ew = word_q.pop_front();
                n_cmp++;
                if (ddr_opload_read_data !== ew) begin n_err++; $display("FAIL spam_data: got %h expected %h", ddr_opload_read_data, ew); end
                last_rd = ew;
            end
            @(negedge clock);
        end
        ddr_chip_enable = 0;
        n_cmp += 2;
        if (dones !== 1) begin n_err++; $display("FAIL spam_done_count: got %0d expected 1", dones); end
        if (done_at !== RL) begin n_err++; $display("FAIL spam_latency: got %0d expected %0d", done_at, RL); end
        do_cmd(0, 0, 19'h00040, '0, '0, "rd_spam_unchanged");
    endtask

    task automatic test_reset_mid_op();
        int dones = 0;
        do_cmd(1, 0, 19'h00030, '1, 64'h5, "wr_30_seed");
        ddr_chip_enable = 1; ddr_write_enable = 1; ddr_burst_mode = 0; ddr_index = 19'h30;
        ddr_opstore_write_mask = '1; ddr_opstore_write_data = 64'hFFFF_0000_FFFF_0000;
        @(posedge clock);
        @(negedge clock);
        ddr_chip_enable = 0;
        @(negedge clock);
        reset_n = 0;
        #1;
        n_cmp++;
        if (ddr_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready: got %b expected 1", ddr_ready); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (ddr_operation_done === 1'b1) dones++;
        end
        reset_n = 1;
        last_rd = '0;
        last_pc = '0;
        n_cmp += 2;
        if (dones !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses expected 0", dones); end
        if (ddr_opload_read_data !== 64'h0) begin n_err++; $display("FAIL abort_opload_cleared: got %h expected 0", ddr_opload_read_data); end
        do_cmd(0, 0, 19'h00030, '0, '0, "rd_30_after_abort");
    endtask

    task automatic test_alias_burst();
        for (int k = 0; k < 8; k++) do_cmd(1, 0, 19'hFF8 + 19'(k), '1, 64'hA000 + 64'(k * 3), "wr_top");
        do_cmd(1, 1, 19'h7FFFF, '1, 64'hBAD, "burst_alias");
        do_cmd(0, 0, 19'h7FFF9, '0, '0, "rd_alias");
    endtask

    task automatic test_back_to_back();
        do_cmd(1, 0, 19'h00050, '1, 64'h0123_4567_89AB_CDEF, "b2b_wr");
        do_cmd(0, 0, 19'h00050, '0, '0, "b2b_rd");
        do_cmd(1, 0, 19'h00050, 64'hFF00_FF00_FF00_FF00, 64'hFFFF_FFFF_FFFF_FFFF, "b2b_wr2");
        do_cmd(0, 1, 19'h00050, '0, '0, "b2b_burst");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_masked_write();
        test_burst();
        test_ce_spam();
        test_reset_mid_op();
        test_alias_burst();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
